ats_alarm_bank: RTL and testbench

//  Parametrised next-generation alarm/timer system: NUM_CLOCKS free-running base clocks, NUM_ALARMS

---
 rtl/ats_pkg.sv | 35 +++
 rtl/ats_clock_counter.sv | 67 ++++++
 rtl/ats_alarm_bank.sv | 166 ++++++++++++++++
 tb/tb_ats_alarm_bank.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/ats_pkg.sv
// Shared opcode/status encodings, FSM states and command-word field positions for the
// alarm/timer core.
package ats_pkg;

  localparam int OP_HI    = 15;
  localparam int OP_LO    = 12;
  localparam int LOOP_BIT = 11;
  localparam int AIDX_HI  = 10;
  localparam int AIDX_LO  = 5;
  localparam int CIDX_HI  = 4;
  localparam int CIDX_LO  = 0;

  typedef enum logic [3:0] {
    OP_NOP       = 4'd0,
    OP_CLK_START = 4'd1,
    OP_CLK_STOP  = 4'd2,
    OP_CLK_LOAD  = 4'd3,
    OP_ALM_SET   = 4'd4,
    OP_ALM_CLR   = 4'd5,
    OP_CLK_DIV   = 4'd6
  } opcode_e;

  typedef enum logic [1:0] {
    STAT_OK      = 2'b00,
    STAT_BAD_IDX = 2'b01,
    STAT_BAD_OP  = 2'b10,
    STAT_RSVD    = 2'b11
  } stat_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EXEC = 1'b1
  } state_e;

endpackage

// File: rtl/ats_clock_counter.sv
// One free-running base clock: enable, count and tick strobe.
// With ATS_PRESCALE_EN defined, ticks are divided by a per-clock prescaler.
module ats_clock_counter #(
  parameter int CLK_W   = 16,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               load,
`ifdef ATS_PRESCALE_EN
  input  logic               div,
  input  logic [PRESC_W-1:0] div_val,
`endif
  input  logic [CLK_W-1:0]   load_val,
  output logic [CLK_W-1:0]   count,
  output logic               tick
);
  logic enable;
  logic wr;
  logic presc_hit;

`ifdef ATS_PRESCALE_EN
  logic [PRESC_W-1:0] divisor;
  logic [PRESC_W-1:0] presc_cnt;

  assign wr        = start | stop | load | div;
  assign presc_hit = (presc_cnt == divisor);

  always_ff @(posedge clk) begin
    if (reset) begin
      divisor   <= '0;
      presc_cnt <= '0;
    end else if (div) begin
      divisor   <= div_val;
      presc_cnt <= '0;
    end else if (load) begin
      presc_cnt <= '0;
    end else if (enable) begin
      presc_cnt <= presc_hit ? '0 : presc_cnt + PRESC_W'(1);
    end
  end
`else
  logic [PRESC_W-1:0] unused_presc;

  assign unused_presc = '0;
  assign wr           = start | stop | load;
  assign presc_hit    = 1'b1;
`endif

  // A command write to this clock takes precedence over its tick that cycle.
  assign tick = enable && presc_hit && !wr;

  always_ff @(posedge clk) begin
    if (reset) begin
      enable <= 1'b0;
      count  <= '0;
    end else begin
      if (start)     enable <= 1'b1;
      else if (stop) enable <= 1'b0;
      if (load)      count <= load_val;
      else if (tick) count <= count + CLK_W'(1);
    end
  end

endmodule

// File: rtl/ats_alarm_bank.sv
// Timer core: NUM_CLOCKS base clocks, NUM_ALARMS compare alarms, req/ready command port.
// Optional per-clock prescaler (opcode CLK_DIV) is built when ATS_PRESCALE_EN is defined.
module ats_alarm_bank
  import ats_pkg::*;
#(
  parameter int NUM_CLOCKS = 16,
  parameter int NUM_ALARMS = 24,
  parameter int CLK_W      = 16,
  parameter int FIN_CYCLES = 2,
  parameter int PRESC_W    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic [15:0]           ctrlA,
  input  logic [CLK_W-1:0]      ctrlB,
  output logic                  ready,
  output logic [1:0]            stat,
  output logic [NUM_ALARMS-1:0] data
);
  localparam int PC_W = (FIN_CYCLES > 1) ? $clog2(FIN_CYCLES) : 1;

  state_e           state_q, state_d;
  stat_e            stat_q, stat_d;
  logic [15:0]      cmd_a;
  logic [CLK_W-1:0] cmd_b;
  opcode_e          op;
  logic [4:0]       cidx;
  logic [5:0]       aidx;
  logic             cmd_loop;
  logic             cidx_ok;
  logic             aidx_ok;
  logic             do_cmd;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      stat_q  <= STAT_OK;
    end else begin
      state_q <= state_d;
      if (state_q == S_EXEC) stat_q <= stat_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && req) begin
      cmd_a <= ctrlA;
      cmd_b <= ctrlB;
    end
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (req) state_d = S_EXEC;
      end
      S_EXEC:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign op       = opcode_e'(cmd_a[OP_HI:OP_LO]);
  assign cmd_loop = cmd_a[LOOP_BIT];
  assign aidx     = cmd_a[AIDX_HI:AIDX_LO];
  assign cidx     = cmd_a[CIDX_HI:CIDX_LO];
  assign cidx_ok  = ({1'b0, cidx} < 6'(NUM_CLOCKS));
  assign aidx_ok  = ({1'b0, aidx} < 7'(NUM_ALARMS));

  always_comb begin
    stat_d = STAT_OK;
    case (op)
      OP_NOP:                               stat_d = STAT_OK;
      OP_CLK_START, OP_CLK_STOP, OP_CLK_LOAD: if (!cidx_ok) stat_d = STAT_BAD_IDX;
`ifdef ATS_PRESCALE_EN
      OP_CLK_DIV:                           if (!cidx_ok) stat_d = STAT_BAD_IDX;
`endif
      OP_ALM_SET:                           if (!cidx_ok || !aidx_ok) stat_d = STAT_BAD_IDX;
      OP_ALM_CLR:                           if (!aidx_ok) stat_d = STAT_BAD_IDX;
      default:                              stat_d = STAT_BAD_OP;
    endcase
  end

  assign do_cmd = (state_q == S_EXEC) && (stat_d == STAT_OK);
  assign stat   = stat_q;

  // Clock array is padded to the full 5-bit select range; unused slots never tick.
  logic [CLK_W-1:0] clk_count [32];
  logic [31:0]      clk_tick;

  for (genvar c = 0; c < 32; c++) begin : g_clk
    if (c < NUM_CLOCKS) begin : g_on
      logic hit;
      assign hit = do_cmd && (cidx == 5'(c));
      ats_clock_counter #(
        .CLK_W  (CLK_W),
        .PRESC_W(PRESC_W)
      ) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .start   (hit && op == OP_CLK_START),
        .stop    (hit && op == OP_CLK_STOP),
        .load    (hit && op == OP_CLK_LOAD),
`ifdef ATS_PRESCALE_EN
        .div     (hit && op == OP_CLK_DIV),
        .div_val (PRESC_W'(cmd_b)),
`endif
        .load_val(cmd_b),
        .count   (clk_count[c]),
        .tick    (clk_tick[c])
      );
    end else begin : g_off
      assign clk_count[c] = '0;
      assign clk_tick[c]  = 1'b0;
    end
  end

  for (genvar a = 0; a < NUM_ALARMS; a++) begin : g_alm
    logic             en;
    logic             fin;
    logic             loop;
    logic [4:0]       sel;
    logic [CLK_W-1:0] value;
    logic [PC_W-1:0]  pulse_cnt;
    logic             set_hit;
    logic             clr_hit;
    logic             match;

    assign set_hit = do_cmd && (aidx == 6'(a)) && (op == OP_ALM_SET);
    assign clr_hit = do_cmd && (aidx == 6'(a)) && (op == OP_ALM_CLR);
    // Only a tick onto value matches; a running pulse swallows further matches.
    assign match   = en && !fin && clk_tick[sel] &&
                     ((clk_count[sel] + CLK_W'(1)) == value);
    assign data[a] = fin;

    always_ff @(posedge clk) begin
      if (reset) begin
        en        <= 1'b0;
        fin       <= 1'b0;
        pulse_cnt <= '0;
      end else if (set_hit || clr_hit) begin
        en        <= set_hit;
        fin       <= 1'b0;
        pulse_cnt <= '0;
      end else if (match) begin
        fin       <= 1'b1;
        pulse_cnt <= PC_W'(FIN_CYCLES - 1);
        if (!loop) en <= 1'b0;
      end else if (fin) begin
        if (pulse_cnt == '0) fin <= 1'b0;
        else                 pulse_cnt <= pulse_cnt - PC_W'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (set_hit) begin
        loop  <= cmd_loop;
        sel   <= cidx;
        value <= cmd_b;
      end
    end
  end

endmodule

// File: tb/tb_ats_alarm_bank.sv
// Directed self-checking bench for ats_alarm_bank (CLK_W=4 so wrap behaviour is quick to reach).
module tb_ats_alarm_bank;
  localparam int NC = 16;
  localparam int NA = 24;
  localparam int CW = 4;
  localparam int FC = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          req;
  logic [15:0]   ctrlA;
  logic [CW-1:0] ctrlB;
  logic          ready;
  logic [1:0]    stat;
  logic [NA-1:0] data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ats_alarm_bank #(
    .NUM_CLOCKS(NC),
    .NUM_ALARMS(NA),
    .CLK_W     (CW),
    .FIN_CYCLES(FC),
    .PRESC_W   (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .req  (req),
    .ctrlA(ctrlA),
    .ctrlB(ctrlB),
    .ready(ready),
    .stat (stat),
    .data (data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue one command: accepted on the first edge, applied on the second.
  task automatic cmd(input logic [3:0] op, input logic lp, input logic [5:0] ai,
                     input logic [4:0] ci, input logic [CW-1:0] b,
                     input logic [1:0] exp_stat, input string tag);
    req   = 1'b1;
    ctrlA = {op, lp, ai, ci};
    ctrlB = b;
    @(posedge clk);
    #1;
    req = 1'b0;
    chk({tag, "_ready_exec"}, 32'(ready), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_stat"}, 32'(stat), 32'(exp_stat));
  endtask

  initial begin
    logic [NA-1:0] exp_d;
    reset = 1'b1;
    req   = 1'b0;
    ctrlA = '0;
    ctrlB = '0;
    step(3);
    reset = 1'b0;

    // Reset state
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_stat",  32'(stat),  32'd0);
    chk("rst_data",  32'(data),  32'd0);
    for (int k = 0; k < 50; k++) begin
      step(1);
      chk($sformatf("idle_data_%0d", k), 32'(data), 32'd0);
      chk($sformatf("idle_ready_%0d", k), 32'(ready), 32'd1);
    end

    // Errors: a0 armed on c0 would fire if a bad command started c0
    cmd(4'd4, 1'b0, 6'd0,  5'd0,  4'd1, 2'b00, "err_set_a0");
    cmd(4'd1, 1'b0, 6'd0,  5'd16, 4'd0, 2'b01, "err_start_c16");
    cmd(4'd15, 1'b0, 6'd0, 5'd0,  4'd0, 2'b10, "err_op15");
    cmd(4'd4, 1'b0, 6'd40, 5'd0,  4'd1, 2'b01, "err_set_a40");
    for (int k = 0; k < 20; k++) begin
      step(1);
      chk($sformatf("err_data_%0d", k), 32'(data), 32'd0);
    end
    chk("err_stat_hold", 32'(stat), 32'd1);
    cmd(4'd5, 1'b0, 6'd0, 5'd0, 4'd0, 2'b00, "err_clr_a0");

    // One-shot: a3 on c0 at value 5
    cmd(4'd3, 1'b0, 6'd0, 5'd0, 4'd0, 2'b00, "os_load");
    cmd(4'd4, 1'b0, 6'd3, 5'd0, 4'd5, 2'b00, "os_set");
    cmd(4'd1, 1'b0, 6'd0, 5'd0, 4'd0, 2'b00, "os_start");
    for (int k = 1; k <= 40; k++) begin
      step(1);
      exp_d = (k == 5 || k == 6) ? (NA'(1) << 3) : '0;
      chk($sformatf("oneshot_%0d", k), 32'(data), 32'(exp_d));
    end
    cmd(4'd2, 1'b0, 6'd0, 5'd0, 4'd0, 2'b00, "os_stop");
    cmd(4'd5, 1'b0, 6'd3, 5'd0, 4'd0, 2'b00, "os_clr");

    // Loop/wrap: a1 on c2 at value 3, re-fires every 16 ticks
    cmd(4'd4, 1'b1, 6'd1, 5'd2, 4'd3, 2'b00, "lp_set");
    cmd(4'd1, 1'b0, 6'd0, 5'd2, 4'd0, 2'b00, "lp_start");
    for (int k = 1; k <= 40; k++) begin
      step(1);
      exp_d = ((k % 16) == 3 || (k % 16) == 4) ? (NA'(1) << 1) : '0;
      chk($sformatf("loop_%0d", k), 32'(data), 32'(exp_d));
    end
    cmd(4'd2, 1'b0, 6'd0, 5'd2, 4'd0, 2'b00, "lp_stop");
    cmd(4'd5, 1'b0, 6'd1, 5'd0, 4'd0, 2'b00, "lp_clr");

    // Collision: LOAD c0=9 lands on the edge where c0 would tick 4->5
    cmd(4'd3, 1'b0, 6'd0, 5'd0, 4'd0, 2'b00, "col_load0");
    cmd(4'd4, 1'b0, 6'd5, 5'd0, 4'd5, 2'b00, "col_set");
    cmd(4'd1, 1'b0, 6'd0, 5'd0, 4'd0, 2'b00, "col_start");
    step(3);
    cmd(4'd3, 1'b0, 6'd0, 5'd0, 4'd9, 2'b00, "col_load9");
    chk("col_nofire", 32'(data), 32'd0);
    for (int j = 1; j <= 20; j++) begin
      step(1);
      exp_d = (j == 12 || j == 13) ? (NA'(1) << 5) : '0;
      chk($sformatf("collide_%0d", j), 32'(data), 32'(exp_d));
    end
    cmd(4'd2, 1'b0, 6'd0, 5'd0, 4'd0, 2'b00, "col_stop");

`ifdef ATS_PRESCALE_EN
    // Prescaler: divisor 3 gives one tick every 4 cycles
    cmd(4'd6, 1'b0, 6'd0, 5'd0, 4'd3, 2'b00, "div_set");
    cmd(4'd3, 1'b0, 6'd0, 5'd0, 4'd0, 2'b00, "div_load");
    cmd(4'd4, 1'b0, 6'd2, 5'd0, 4'd2, 2'b00, "div_alm");
    cmd(4'd1, 1'b0, 6'd0, 5'd0, 4'd0, 2'b00, "div_start");
    for (int k = 1; k <= 12; k++) begin
      step(1);
      exp_d = (k == 8 || k == 9) ? (NA'(1) << 2) : '0;
      chk($sformatf("presc_%0d", k), 32'(data), 32'(exp_d));
    end
    cmd(4'd2, 1'b0, 6'd0, 5'd0, 4'd0, 2'b00, "div_stop");
`else
    cmd(4'd6, 1'b0, 6'd0, 5'd0, 4'd3, 2'b10, "div_off");
    step(4);
    chk("div_off_data", 32'(data), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
